// File: rtl/inta_sequencer_pkg.sv
// ============================================================================
// inta_sequencer_pkg : shared types and constants for the INTA sequencer
//                      and PIC-side blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inta_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PULSE1   = 3'd1,
    ST_GAP      = 3'd2,
    ST_PULSE2   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  localparam int PULSE_CYCLES_DEFAULT = 4;
  localparam int GAP_CYCLES_DEFAULT   = 2;
  localparam int CNT_W                = 4;

  // Acknowledge polarity shared with the PIC side.
  localparam logic INTA_ACTIVE = 1'b0;

  // A timed state lasting N cycles counts N-1 down to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for asynchronous level inputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/inta_sequencer.sv
// ============================================================================
// inta_sequencer : issues the paired INTA pulses to the PIC, captures the
//                  vector on the second pulse and hands it to the CPU core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEFAULT,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       IE,
  input  logic [7:0] D,
  output logic       INTA,
  output logic [7:0] VEC,
  output logic       VEC_VALID,
  input  logic       VEC_READY,
  output logic       BUSY,
  output logic       SPURIOUS
);

  localparam logic [CNT_W-1:0] c_pulse_load = cnt_load(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] c_gap_load   = cnt_load(GAP_CYCLES);

  logic             int_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inta_q;
  logic [7:0]       vec_q;
  logic             valid_q;
  logic             spur_q;
  logic             busy_q;
  logic             cnt_done;

  sync_2ff #(
    .WIDTH (1)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (INT),
    .q_o   (int_s)
  );

  assign cnt_done = (cnt_q == '0);

  // Once PULSE1 is entered the sequence always completes both pulses so the
  // PIC's internal pulse counter stays paired; INT and IE are ignored until
  // the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      inta_q  <= ~INTA_ACTIVE;
      vec_q   <= 8'h00;
      valid_q <= 1'b0;
      spur_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (int_s && IE) begin
            state_q <= ST_PULSE1;
            cnt_q   <= c_pulse_load;
            inta_q  <= INTA_ACTIVE;
            busy_q  <= 1'b1;
          end
        end

        ST_PULSE1: begin
          if (cnt_done) begin
            state_q <= ST_GAP;
            cnt_q   <= c_gap_load;
            inta_q  <= ~INTA_ACTIVE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_done) begin
            state_q <= ST_PULSE2;
            cnt_q   <= c_pulse_load;
            inta_q  <= INTA_ACTIVE;
            spur_q  <= ~int_s;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_PULSE2: begin
          // Vector is sampled while INTA is still low; the PIC has been
          // driving it since the second falling edge.
          if (cnt_done) begin
            state_q <= ST_HOLD;
            inta_q  <= ~INTA_ACTIVE;
            vec_q   <= D;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_HOLD: begin
          if (VEC_READY) begin
            state_q <= ST_COOLDOWN;
            cnt_q   <= c_gap_load;
            valid_q <= 1'b0;
          end
        end

        ST_COOLDOWN: begin
          if (cnt_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          inta_q  <= ~INTA_ACTIVE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign INTA      = inta_q;
  assign VEC       = vec_q;
  assign VEC_VALID = valid_q;
  assign SPURIOUS  = spur_q;
  assign BUSY      = busy_q;

endmodule

`default_nettype wire
